// File: rtl/pending_request_pkg.sv
// ---------------------------------------------------------------------------
// pending_request_pkg
//   Shared types and helpers for the pending request controller slice.
//   - state_e : offer state machine encoding (IDLE, OFFER)
//   - IDX_W() : width of a line index for an N-line request vector
// ---------------------------------------------------------------------------
package pending_request_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Number of bits needed to name one of n request lines.
  function automatic int IDX_W(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/lowest_first_encoder.sv
// ---------------------------------------------------------------------------
// lowest_first_encoder
//   Combinational priority encoder: bit 0 has the highest priority.
//   Ports:
//     cand [N-1:0]      : candidate vector
//     idx  [IDX_W(N)-1:0]: index of the lowest set bit of cand (0 if none)
//     any               : cand has at least one bit set
// ---------------------------------------------------------------------------
module lowest_first_encoder
  import pending_request_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          cand,
  output logic [IDX_W(N)-1:0]   idx,
  output logic                  any
);

  localparam int IW = IDX_W(N);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_request_controller.sv
// ---------------------------------------------------------------------------
// pending_request_controller
//   Captures N request lines into a sticky pending register, masks them and
//   offers the lowest-index unmasked pending line over valid/ready.
//   Parameters:
//     N    : number of request lines (power of two, >= 2)
//     EDGE : 1 = capture rising edges of req_in, 0 = capture levels
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     req_in    : raw request lines
//     mask      : 1 = line excluded from selection (still captured)
//     out_ready : consumer accepts the offered index
//     out_valid : index offer valid
//     out_idx   : offered line index (held while out_valid is low)
//     pending   : current pending register
//     overflow  : one-cycle pulse when a capture hits an already-pending bit
// ---------------------------------------------------------------------------
module pending_request_controller
  import pending_request_pkg::*;
#(
  parameter int N    = 4,
  parameter bit EDGE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_in,
  input  logic [N-1:0]          mask,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [IDX_W(N)-1:0]   out_idx,
  output logic [N-1:0]          pending,
  output logic                  overflow
);

  localparam int IW = IDX_W(N);

  state_e          state_q, state_d;
  logic [N-1:0]    req_q;
  logic [N-1:0]    pending_q, pending_d;
  logic            out_valid_q, out_valid_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic            overflow_q, overflow_d;

  logic [N-1:0]    set;
  logic [N-1:0]    clr;
  logic [N-1:0]    cand;
  logic            accept;
  logic [IW-1:0]   enc_idx;
  logic            enc_any;

  // req_q starts at zero, so a line already high at reset release is seen
  // as a fresh edge in edge mode.
  always_comb begin
    set = EDGE ? (req_in & ~req_q) : req_in;
  end

  assign accept = out_valid_q & out_ready;
  assign cand   = pending_q & ~mask;

  // Clear only the offered bit, and only on the accept cycle.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      if (accept && (out_idx_q == IW'(i))) begin
        clr[i] = 1'b1;
      end
    end
  end

  // Set is ORed in after the clear, so a same-cycle set keeps the bit.
  always_comb begin
    pending_d  = (pending_q & ~clr) | set;
    overflow_d = EDGE && (|(set & pending_q & ~clr));
  end

  lowest_first_encoder #(
    .N (N)
  ) u_encoder (
    .cand (cand),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  // Offer FSM: an offer, once made, is held unchanged until accepted.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          out_idx_d   = enc_idx;
          out_valid_d = 1'b1;
          state_d     = OFFER;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      OFFER: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_in;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
